// File: rtl/dbg_trigger_unit.sv
// ============================================================================
// Module  : dbg_trigger_unit
// Brief   : Execute-address trigger unit (mcontrol-style) that feeds the debug
//           mode controller's breakpoint input. Optional NAPOT matching is
//           enabled by defining DBG_TRIG_NAPOT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dbg_trigger_unit #(
  parameter int NUM_TRIG = 2,
  parameter int PC_WIDTH = 32
) (
  input  logic                cpu_clk,
  input  logic                cpu_rst,
  input  logic                csr_wr_en,
  input  logic [11:0]         csr_addr,
  input  logic [31:0]         csr_wdata,
  output logic [31:0]         csr_rdata,
  input  logic                dec_valid,
  input  logic [PC_WIDTH-1:0] dec_pc,
  input  logic                dbg_mode,
  input  logic                resumereq_w1,
  output logic                breakpoint,
  output logic [2:0]          trig_hit_idx
);

  localparam int SEL_W = (NUM_TRIG > 1) ? $clog2(NUM_TRIG) : 1;

  localparam logic [11:0] c_tselect_addr = 12'h7A0;
  localparam logic [11:0] c_tdata1_addr  = 12'h7A1;
  localparam logic [11:0] c_tdata2_addr  = 12'h7A2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FIRED     = 3'd1,
    ST_WAIT_HALT = 3'd2,
    ST_HALTED    = 3'd3,
    ST_SKIP      = 3'd4
  } state_e;

  state_e              state_q;
  logic                bp_q;
  logic [2:0]          idx_q;
  logic [SEL_W-1:0]    tsel_q;
  logic [NUM_TRIG-1:0] exec_q;
  logic [NUM_TRIG-1:0] hit_q;
  logic [NUM_TRIG-1:0] hit_d;
  logic [PC_WIDTH-1:0] tdata2_q [NUM_TRIG];
`ifdef DBG_TRIG_NAPOT_EN
  logic [NUM_TRIG-1:0] match_q;
`endif

  logic [NUM_TRIG-1:0] w_match;
  logic [2:0]          w_low_idx;
  logic                w_fire;
  logic                w_wr_sel;
  logic                w_wr_t1;
  logic                w_wr_t2;

`ifdef DBG_TRIG_NAPOT_EN
  // t ^ (t+1) sets exactly bits [k:0], k = trailing-ones count of t.
  function automatic logic napot_cmp(input logic [PC_WIDTH-1:0] pc,
                                     input logic [PC_WIDTH-1:0] t);
    logic [PC_WIDTH-1:0] care;
    care = ~(t ^ (t + PC_WIDTH'(1)));
    return ((pc ^ t) & care) == '0;
  endfunction
`endif

  always_comb begin
    w_match   = '0;
    w_low_idx = '0;
    for (int i = 0; i < NUM_TRIG; i++) begin
`ifdef DBG_TRIG_NAPOT_EN
      w_match[i] = exec_q[i] && dec_valid &&
                   (match_q[i] ? napot_cmp(dec_pc, tdata2_q[i])
                               : (dec_pc == tdata2_q[i]));
`else
      w_match[i] = exec_q[i] && dec_valid && (dec_pc == tdata2_q[i]);
`endif
    end
    for (int i = NUM_TRIG - 1; i >= 0; i--) begin
      if (w_match[i]) w_low_idx = 3'(i);
    end
  end

  assign w_fire   = (state_q == ST_IDLE) && !dbg_mode && (|w_match);
  assign w_wr_sel = csr_wr_en && (csr_addr == c_tselect_addr) &&
                    (csr_wdata < 32'(NUM_TRIG));
  assign w_wr_t1  = csr_wr_en && (csr_addr == c_tdata1_addr) && dbg_mode;
  assign w_wr_t2  = csr_wr_en && (csr_addr == c_tdata2_addr) && dbg_mode;

  // Hardware set is OR-ed in after the software value so it wins a collision.
  always_comb begin
    hit_d = hit_q;
    if (w_wr_t1) hit_d[tsel_q] = csr_wdata[20];
    if (w_fire)  hit_d = hit_d | w_match;
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      c_tselect_addr: csr_rdata = 32'(tsel_q);
      c_tdata1_addr: begin
        csr_rdata[31:28] = 4'h2;
        csr_rdata[27]    = 1'b1;
        csr_rdata[20]    = hit_q[tsel_q];
`ifdef DBG_TRIG_NAPOT_EN
        csr_rdata[7]     = match_q[tsel_q];
`endif
        csr_rdata[2]     = exec_q[tsel_q];
      end
      c_tdata2_addr: csr_rdata = 32'(tdata2_q[tsel_q]);
      default:       csr_rdata = '0;
    endcase
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q <= ST_IDLE;
      bp_q    <= 1'b0;
      idx_q   <= '0;
      tsel_q  <= '0;
      exec_q  <= '0;
      hit_q   <= '0;
`ifdef DBG_TRIG_NAPOT_EN
      match_q <= '0;
`endif
      for (int i = 0; i < NUM_TRIG; i++) tdata2_q[i] <= '0;
    end else begin
      hit_q <= hit_d;
      bp_q  <= 1'b0;
      if (w_wr_sel) tsel_q <= csr_wdata[SEL_W-1:0];
      if (w_wr_t1) begin
        exec_q[tsel_q]  <= csr_wdata[2];
`ifdef DBG_TRIG_NAPOT_EN
        match_q[tsel_q] <= (csr_wdata[10:7] == 4'd1);
`endif
      end
      if (w_wr_t2) tdata2_q[tsel_q] <= csr_wdata[PC_WIDTH-1:0];

      case (state_q)
        ST_IDLE: begin
          if (dbg_mode) begin
            state_q <= ST_HALTED;
          end else if (w_fire) begin
            state_q <= ST_FIRED;
            bp_q    <= 1'b1;
            idx_q   <= w_low_idx;
          end
        end
        ST_FIRED:     state_q <= ST_WAIT_HALT;
        ST_WAIT_HALT: if (dbg_mode) state_q <= ST_HALTED;
        ST_HALTED:    if (resumereq_w1 || !dbg_mode) state_q <= ST_SKIP;
        // The resumed instruction is swallowed here so it cannot re-trap.
        ST_SKIP:      if (dec_valid) state_q <= ST_IDLE;
        default:      state_q <= ST_IDLE;
      endcase
    end
  end

  assign breakpoint   = bp_q;
  assign trig_hit_idx = idx_q;

endmodule

`default_nettype wire

// File: tb/tb_dbg_trigger_unit.sv
// ============================================================================
// Module  : tb_dbg_trigger_unit
// Brief   : Self-checking bench for dbg_trigger_unit (CSR vectors, directed
//           fire/skip/reset sequences, randomized run against a model).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dbg_trigger_unit;

  localparam int NT = 2;
`ifdef DBG_TRIG_NAPOT_EN
  localparam bit NAPOT = 1'b1;
`else
  localparam bit NAPOT = 1'b0;
`endif

  logic        cpu_clk;
  logic        cpu_rst;
  logic        csr_wr_en;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic        dbg_mode;
  logic        resumereq_w1;
  logic        breakpoint;
  logic [2:0]  trig_hit_idx;

  dbg_trigger_unit #(.NUM_TRIG(NT), .PC_WIDTH(32)) dut (
    .cpu_clk      (cpu_clk),
    .cpu_rst      (cpu_rst),
    .csr_wr_en    (csr_wr_en),
    .csr_addr     (csr_addr),
    .csr_wdata    (csr_wdata),
    .csr_rdata    (csr_rdata),
    .dec_valid    (dec_valid),
    .dec_pc       (dec_pc),
    .dbg_mode     (dbg_mode),
    .resumereq_w1 (resumereq_w1),
    .breakpoint   (breakpoint),
    .trig_hit_idx (trig_hit_idx)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  bit [31:0] m_t2    [NT];
  bit        m_exec  [NT];
  bit        m_hit   [NT];
  bit        m_match [NT];
  int        m_sel;
  int        m_ph;     // 0 idle, 1 fired, 2 wait-halt, 3 halted, 4 skip
  bit        m_bp;
  int        m_idx;

  task automatic model_reset();
    for (int i = 0; i < NT; i++) begin
      m_t2[i] = 0; m_exec[i] = 0; m_hit[i] = 0; m_match[i] = 0;
    end
    m_sel = 0; m_ph = 0; m_bp = 0; m_idx = 0;
  endtask

  function automatic bit m_cmp(input bit [31:0] pc, input bit [31:0] t, input bit napot);
    int k;
    if (!napot) return pc == t;
    k = 0;
    while (k < 32 && t[k]) k++;
    if (k >= 31) return 1'b1;
    return (pc >> (k + 1)) == (t >> (k + 1));
  endfunction

  function automatic logic [31:0] m_rdata(input logic [11:0] a);
    logic [31:0] r;
    r = 0;
    if (a == 12'h7A0) r = 32'(m_sel);
    else if (a == 12'h7A1) begin
      r = 32'h2800_0000;
      r[20] = m_hit[m_sel];
      r[7]  = m_match[m_sel];
      r[2]  = m_exec[m_sel];
    end else if (a == 12'h7A2) r = m_t2[m_sel];
    return r;
  endfunction

  // Advances the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit mt [NT];
    bit any;
    int low, s;
    any = 0; low = 0;
    for (int i = 0; i < NT; i++) begin
      mt[i] = m_exec[i] && dec_valid && m_cmp(dec_pc, m_t2[i], m_match[i]);
      any |= mt[i];
    end
    for (int i = NT - 1; i >= 0; i--) if (mt[i]) low = i;
    s = m_sel;
    if (csr_wr_en && csr_addr == 12'h7A0 && csr_wdata < NT) m_sel = int'(csr_wdata);
    if (csr_wr_en && csr_addr == 12'h7A1 && dbg_mode) begin
      m_exec[s]  = csr_wdata[2];
      m_hit[s]   = csr_wdata[20];
      m_match[s] = NAPOT && (csr_wdata[10:7] == 4'd1);
    end
    if (csr_wr_en && csr_addr == 12'h7A2 && dbg_mode) m_t2[s] = csr_wdata;
    m_bp = 0;
    case (m_ph)
      0: if (dbg_mode) m_ph = 3;
         else if (any) begin
           m_ph = 1; m_bp = 1; m_idx = low;
           for (int i = 0; i < NT; i++) if (mt[i]) m_hit[i] = 1;
         end
      1: m_ph = 2;
      2: if (dbg_mode) m_ph = 3;
      3: if (resumereq_w1 || !dbg_mode) m_ph = 4;
      default: if (dec_valid) m_ph = 0;
    endcase
  endtask

  task automatic do_reset();
    cpu_rst = 1; csr_wr_en = 0; csr_addr = 0; csr_wdata = 0;
    dec_valid = 0; dec_pc = 0; dbg_mode = 0; resumereq_w1 = 0;
    tick(); tick();
    cpu_rst = 0;
    model_reset();
  endtask

  task automatic csr_w(input logic [11:0] a, input logic [31:0] d);
    csr_wr_en = 1; csr_addr = a; csr_wdata = d;
    tick();
    csr_wr_en = 0;
  endtask

  task automatic dec(input logic [31:0] pc);
    dec_valid = 1; dec_pc = pc;
    tick();
    dec_valid = 0;
  endtask

  task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    chk(name, csr_rdata, exp);
  endtask

  // Program one trigger in debug mode and return to normal mode with the
  // post-debug skip already consumed by a non-matching decode.
  task automatic arm(input int sel, input logic [31:0] t2, input logic [31:0] t1);
    dbg_mode = 1; tick();
    csr_w(12'h7A0, 32'(sel));
    csr_w(12'h7A2, t2);
    csr_w(12'h7A1, t1);
    dbg_mode = 0; tick();
    dec(32'h0000_0000);
  endtask

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    bit          dbg;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [17];
  logic [11:0] addrs [4] = '{12'h7A0, 12'h7A1, 12'h7A2, 12'h7A3};
  logic [31:0] pcs   [4] = '{32'h0000_0100, 32'h0000_0104, 32'h0000_10FF, 32'h0000_1010};

  initial begin
    vt[0]  = '{0, 12'h7A0, 32'h0,         0, 32'h0};
    vt[1]  = '{0, 12'h7A1, 32'h0,         0, 32'h2800_0000};
    vt[2]  = '{0, 12'h7A2, 32'h0,         0, 32'h0};
    vt[3]  = '{0, 12'h7A3, 32'h0,         0, 32'h0};
    vt[4]  = '{1, 12'h7A2, 32'h100,       1, 32'h100};
    vt[5]  = '{1, 12'h7A1, 32'hFFFF_FFFF, 1, 32'h2810_0004};
    vt[6]  = '{1, 12'h7A1, 32'h0,         1, 32'h2800_0000};
    vt[7]  = '{1, 12'h7A2, 32'h200,       0, 32'h100};
    vt[8]  = '{1, 12'h7A0, 32'h5,         0, 32'h0};
    vt[9]  = '{1, 12'h7A0, 32'h1,         0, 32'h1};
    vt[10] = '{0, 12'h7A2, 32'h0,         0, 32'h0};
    vt[11] = '{1, 12'h7A1, 32'h4,         0, 32'h2800_0000};
    vt[12] = '{1, 12'h7A0, 32'h2,         0, 32'h1};
    vt[13] = '{1, 12'h7A1, 32'h84,        1, NAPOT ? 32'h2800_0084 : 32'h2800_0004};
    vt[14] = '{1, 12'h7A0, 32'h0,         1, 32'h0};
    vt[15] = '{0, 12'h7A2, 32'h0,         1, 32'h100};
    vt[16] = '{1, 12'h7A3, 32'hFFFF,      1, 32'h0};

    do_reset();
    chk("reset_bp", {31'b0, breakpoint}, 32'h0);
    chk("reset_idx", {29'b0, trig_hit_idx}, 32'h0);
    for (int i = 0; i < 17; i++) begin
      csr_wr_en = vt[i].wr; csr_addr = vt[i].addr;
      csr_wdata = vt[i].wdata; dbg_mode = vt[i].dbg;
      tick();
      csr_wr_en = 0;
      #1;
      chk($sformatf("vec%0d", i), csr_rdata, vt[i].exp);
    end

    // Exact fire, one-cycle pulse, hit bit
    do_reset();
    arm(0, 32'h100, 32'h4);
    chk("pre_fire_bp", {31'b0, breakpoint}, 32'h0);
    dec(32'h100);
    chk("fire_bp", {31'b0, breakpoint}, 32'h1);
    chk("fire_idx", {29'b0, trig_hit_idx}, 32'h0);
    tick();
    chk("fire_one_cycle", {31'b0, breakpoint}, 32'h0);
    rd_chk("fire_hit", 12'h7A1, 32'h2810_0004);

    // Halt, resume, skip the resumed instruction, then fire again
    dbg_mode = 1; tick();
    resumereq_w1 = 1; tick();
    resumereq_w1 = 0; dbg_mode = 0;
    dec(32'h100);
    chk("skip_bp", {31'b0, breakpoint}, 32'h0);
    tick();
    chk("skip_bp2", {31'b0, breakpoint}, 32'h0);
    dec(32'h104);
    chk("other_pc_bp", {31'b0, breakpoint}, 32'h0);
    dec(32'h100);
    chk("refire_bp", {31'b0, breakpoint}, 32'h1);

    // Dual match: one pulse, both hit bits, lowest index
    do_reset();
    arm(0, 32'h300, 32'h4);
    arm(1, 32'h300, 32'h4);
    dec(32'h300);
    chk("dual_bp", {31'b0, breakpoint}, 32'h1);
    chk("dual_idx", {29'b0, trig_hit_idx}, 32'h0);
    tick();
    chk("dual_one_cycle", {31'b0, breakpoint}, 32'h0);
    dbg_mode = 1; tick();
    rd_chk("dual_hit1", 12'h7A1, 32'h2810_0004);
    csr_w(12'h7A0, 32'h0);
    rd_chk("dual_hit0", 12'h7A1, 32'h2810_0004);

    // Trigger 1 alone fires with index 1, then reset while in FIRED
    do_reset();
    arm(1, 32'h400, 32'h4);
    dec(32'h400);
    chk("idx1_bp", {31'b0, breakpoint}, 32'h1);
    chk("idx1_idx", {29'b0, trig_hit_idx}, 32'h1);
    cpu_rst = 1;
    #1;
    chk("rst_bp", {31'b0, breakpoint}, 32'h0);
    chk("rst_idx", {29'b0, trig_hit_idx}, 32'h0);
    rd_chk("rst_tsel", 12'h7A0, 32'h0);
    rd_chk("rst_tdata1", 12'h7A1, 32'h2800_0000);
    rd_chk("rst_tdata2", 12'h7A2, 32'h0);
    tick();
    cpu_rst = 0;

`ifdef DBG_TRIG_NAPOT_EN
    begin
      logic [31:0] npc [3] = '{32'h1000, 32'h11FC, 32'h1200};
      logic [31:0] nexp [3] = '{32'h1, 32'h1, 32'h0};
      for (int i = 0; i < 3; i++) begin
        do_reset();
        arm(0, 32'h10FF, 32'h84);
        dec(npc[i]);
        chk($sformatf("napot%0d_bp", i), {31'b0, breakpoint}, nexp[i]);
      end
    end
`endif

    // Randomized run against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      csr_addr = addrs[$urandom_range(0, 3)];
      csr_wr_en = (i < 40) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 9) == 0);
      case (csr_addr)
        12'h7A0: csr_wdata = $urandom_range(0, 3);
        12'h7A1: begin
          csr_wdata = $urandom;
          if ($urandom_range(0, 1) == 0) csr_wdata[10:7] = 4'd1;
          if ($urandom_range(0, 3) != 0) csr_wdata[2] = 1'b1;
        end
        12'h7A2: csr_wdata = pcs[$urandom_range(0, 3)];
        default: csr_wdata = $urandom;
      endcase
      dec_valid = ($urandom_range(0, 9) < 6);
      dec_pc = ($urandom_range(0, 7) == 0) ? $urandom : pcs[$urandom_range(0, 3)];
      if (i < 40) dbg_mode = 1;
      else if (m_ph == 2 && $urandom_range(0, 3) == 0) dbg_mode = 1;
      else if ($urandom_range(0, 15) == 0) dbg_mode = ~dbg_mode;
      resumereq_w1 = ($urandom_range(0, 9) == 0);
      model_step();
      tick();
      chk("rand_bp", {31'b0, breakpoint}, {31'b0, m_bp});
      chk("rand_idx", {29'b0, trig_hit_idx}, 32'(m_idx));
      chk("rand_rdata", csr_rdata, m_rdata(csr_addr));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dbg_trigger_unit.md
Name: dbg_trigger_unit

Overview:
- Hardware execute-address trigger block (RISC-V debug "mcontrol"-style, execute only).
- Sits directly upstream of the core debug mode controller and produces its `breakpoint` input.
- Holds NUM_TRIG PC comparators, which are programmed through the tselect/tdata1/tdata2 CSRs.
- Sequences fire → halt → resume so that a resumed hart does not re-trap on the same instruction.

Parameters:
- NUM_TRIG, 2, number of trigger comparators; legal range 1..8.
- PC_WIDTH, 32, width of the PC and of tdata2.

Ports:
- cpu_clk  in  1  core clock.
- cpu_rst  in  1  reset, asynchronous, active-high.
- csr_wr_en  in  1  CSR write strobe.
- csr_addr  in  12  CSR address.
- csr_wdata  in  32  CSR write data.
- csr_rdata  out  32  CSR read data; combinational.
- dec_valid  in  1  a valid instruction is in decode.
- dec_pc  in  PC_WIDTH  PC of the decode instruction.
- dbg_mode  in  1  core is in debug mode.
- resumereq_w1  in  1  one-cycle resume request pulse.
- breakpoint  out  1  one-cycle trigger-fire pulse to the debug mode controller.
- trig_hit_idx  out  3  index of the lowest matching trigger, captured when breakpoint fires.

Behaviour:

CSR map:
- tselect 0x7A0.
  - Write takes effect only if csr_wdata < NUM_TRIG; otherwise the write is ignored.
  - Reset value 0.
- tdata1 0x7A1, for the trigger selected by tselect:
  - [31:28] type, reads 2, read-only.
  - [27] dmode, reads 1, read-only.
  - [20] hit: set by hardware; software may write it.
  - [10:7] match, described under Optional Feature.
  - [2] execute enable.
  - All other bits read 0.
- tdata2 0x7A2, for the selected trigger: compare address, PC_WIDTH bits, zero-extended on read.
- Write rules:
  - tdata1 and tdata2 writes are accepted only while dbg_mode=1; otherwise they are dropped.
  - tselect is writable in any mode.
- Read rules: csr_rdata=0 for any address other than the three above.
- Reset values: every execute, hit, match and tdata2 field is 0.

Match:
- Trigger i matches when execute[i]=1, dec_valid=1 and the address comparison against tdata2[i] holds.
- Match is evaluated only in state IDLE with dbg_mode=0.

FSM: states IDLE, FIRED, WAIT_HALT, HALTED, SKIP; reset state IDLE.
- IDLE:
  - On any match, next cycle: breakpoint=1, hit bits of all matching triggers set, trig_hit_idx = lowest matching index.
  - State moves to FIRED.
- FIRED: breakpoint is held for exactly one cycle, then the state moves to WAIT_HALT.
- WAIT_HALT: stays until dbg_mode=1, then moves to HALTED. No new matches are taken.
- HALTED:
  - On resumereq_w1=1, moves to SKIP.
  - If dbg_mode falls without a resumereq_w1 (dret), also moves to SKIP.
- SKIP: the first dec_valid=1 cycle is never matched; the state then returns to IDLE.
- Debug entry from another source: if dbg_mode=1 is seen while in IDLE, move to HALTED.

Outputs and conflicts:
- breakpoint latency: 1 cycle after the matching dec_valid cycle.
- breakpoint is 0 in every state except FIRED.
- trig_hit_idx holds its value until the next fire; reset value 0.
- Same-cycle tdata2 write and match: the comparison uses the old value.
- Same-cycle software write of hit and hardware set of hit: hardware set wins (hit=1).
- cpu_rst asserted in any state: immediate return to IDLE, breakpoint=0, all CSR fields at their reset values.

Optional Feature:
- Macro: DBG_TRIG_NAPOT_EN.
- Defined:
  - match field is writable with values 0 or 1; any other value is stored as 0.
  - match=0: exact compare, dec_pc==tdata2.
  - match=1: NAPOT compare. Let k = number of trailing 1s in tdata2. A match occurs when dec_pc and tdata2 are equal above bit k; bits [k:0] are ignored.
- Not defined: match field is read-only 0 and only exact compare is implemented.

Test Plan:
- Exact-match fire:
  - Stimulus: dbg_mode=1; write tselect=0, tdata2=0x0000_0100, tdata1 execute=1; dbg_mode=0; then dec_valid with dec_pc=0x100.
  - Response: breakpoint=1 for exactly one cycle, 1 cycle later; tdata1[20]=1; trig_hit_idx=0.
- Skip after resume:
  - Stimulus: from the fire above, dbg_mode=1, then resumereq_w1 pulse, dbg_mode=0, dec_pc=0x100 presented again.
  - Response: no breakpoint; the next dec_pc=0x100 after a different PC fires again.
- Write protection:
  - Stimulus: dbg_mode=0; write tdata2=0x200 and tselect=5 with NUM_TRIG=2.
  - Response: tdata2 reads back unchanged; tselect reads back unchanged.
- Dual match:
  - Stimulus: triggers 0 and 1 both set to 0x300; dec_pc=0x300.
  - Response: one breakpoint pulse; both hit bits=1; trig_hit_idx=0.
- NAPOT (with DBG_TRIG_NAPOT_EN):
  - Stimulus: tdata2=0x0000_10FF, match=1.
  - Response: dec_pc=0x1000 and dec_pc=0x11FC fire; dec_pc=0x1200 does not.
- Reset mid-operation:
  - Stimulus: assert cpu_rst in FIRED.
  - Response: breakpoint=0 immediately; all CSRs read 0 except the type and dmode fields.
